// File: rtl/alarm_key_entry_pkg.sv
// Shared definitions for the alarm-clock keypad front-end: FSM encoding,
// key code limits and the BCD HH:MM limits also used by the alarm register and time counter.
package alarm_key_entry_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ENTRY      = 2'd1,
        SHOW_ALARM = 2'd2
    } state_e;

    localparam logic [3:0] KEY_NONE     = 4'd10;
    localparam logic [3:0] DIGIT_MAX    = 4'd9;
    localparam logic [3:0] HR_TENS_MAX  = 4'd2;
    localparam logic [3:0] HR_UNITS_MAX = 4'd3;
    localparam logic [3:0] MIN_TENS_MAX = 4'd5;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= DIGIT_MAX;
    endfunction

    // Units-of-minute needs no check: any BCD digit 0-9 is legal there.
    function automatic logic bcd_time_ok(input logic [3:0] ms_hr,
                                         input logic [3:0] ls_hr,
                                         input logic [3:0] ms_min);
        logic ok;
        ok = (ms_hr <= HR_TENS_MAX) && (ms_min <= MIN_TENS_MAX);
        if (ms_hr == HR_TENS_MAX)
            ok = ok && (ls_hr <= HR_UNITS_MAX);
        return ok;
    endfunction

endpackage

// File: rtl/alarm_key_shift.sv
// Four-digit BCD shift buffer with saturating digit count.
// clr and shift together yield a buffer of 0,0,0,din with count 1.
module alarm_key_shift
    import alarm_key_entry_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clr,
    input  logic       shift,
    input  logic [3:0] din,
    output logic [3:0] d3,
    output logic [3:0] d2,
    output logic [3:0] d1,
    output logic [3:0] d0,
    output logic [2:0] count
);

    logic [3:0] d3_q, d2_q, d1_q, d0_q;
    logic [3:0] d3_d, d2_d, d1_d, d0_d;
    logic [2:0] count_q, count_d;

    logic [3:0] b3, b2, b1, b0;
    logic [2:0] bcnt;

    always_comb begin
        b3   = clr ? 4'd0 : d3_q;
        b2   = clr ? 4'd0 : d2_q;
        b1   = clr ? 4'd0 : d1_q;
        b0   = clr ? 4'd0 : d0_q;
        bcnt = clr ? 3'd0 : count_q;

        d3_d    = b3;
        d2_d    = b2;
        d1_d    = b1;
        d0_d    = b0;
        count_d = bcnt;

        if (shift) begin
            d3_d    = b2;
            d2_d    = b1;
            d1_d    = b0;
            d0_d    = din;
            count_d = (bcnt == 3'd4) ? bcnt : bcnt + 3'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            d3_q    <= 4'd0;
            d2_q    <= 4'd0;
            d1_q    <= 4'd0;
            d0_q    <= 4'd0;
            count_q <= 3'd0;
        end else begin
            d3_q    <= d3_d;
            d2_q    <= d2_d;
            d1_q    <= d1_d;
            d0_q    <= d0_d;
            count_q <= count_d;
        end
    end

    assign d3    = d3_q;
    assign d2    = d2_q;
    assign d1    = d1_q;
    assign d0    = d0_q;
    assign count = count_q;

endmodule

// File: rtl/alarm_key_entry.sv
// Keypad front-end: collects HH:MM digits, validates them on a button press
// and strobes the alarm register or time counter. All outputs registered.
module alarm_key_entry
    import alarm_key_entry_pkg::*;
#(
    parameter int TIMEOUT_S = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       one_second,
    input  logic [3:0] key,
    input  logic       key_valid,
    input  logic       alarm_button,
    input  logic       time_button,
    output logic [3:0] new_alarm_ms_hr,
    output logic [3:0] new_alarm_ls_hr,
    output logic [3:0] new_alarm_ms_min,
    output logic [3:0] new_alarm_ls_min,
    output logic       load_new_alarm,
    output logic       load_new_time,
    output logic       show_new_time,
    output logic       show_alarm,
    output logic       entry_error
);

    localparam logic [3:0] TIMEOUT_LIM = 4'(TIMEOUT_S);

    state_e     state_q, state_d;
    logic       alarm_prev_q, alarm_prev_d;
    logic       time_prev_q, time_prev_d;
    logic [3:0] timeout_q, timeout_d;
    logic       load_alarm_q, load_alarm_d;
    logic       load_time_q, load_time_d;
    logic       err_q, err_d;
    logic       show_nt_q, show_nt_d;
    logic       show_al_q, show_al_d;

    logic       alarm_rise, time_rise, digit_ok;
    logic       buf_clr, buf_shift;
    logic [3:0] ms_hr, ls_hr, ms_min, ls_min;
    logic [2:0] count;

    alarm_key_shift u_shift (
        .clock (clock),
        .reset (reset),
        .clr   (buf_clr),
        .shift (buf_shift),
        .din   (key),
        .d3    (ms_hr),
        .d2    (ls_hr),
        .d1    (ms_min),
        .d0    (ls_min),
        .count (count)
    );

    always_comb begin
        alarm_rise   = alarm_button & ~alarm_prev_q;
        time_rise    = time_button & ~time_prev_q;
        digit_ok     = key_valid & is_digit(key);

        state_d      = state_q;
        timeout_d    = timeout_q;
        buf_clr      = 1'b0;
        buf_shift    = 1'b0;
        load_alarm_d = 1'b0;
        load_time_d  = 1'b0;
        err_d        = 1'b0;
        alarm_prev_d = alarm_button;
        time_prev_d  = time_button;

        case (state_q)
            IDLE: begin
                if (alarm_rise) begin
                    state_d = SHOW_ALARM;
                end else if (digit_ok) begin
                    buf_clr   = 1'b1;
                    buf_shift = 1'b1;
                    timeout_d = 4'd0;
                    state_d   = ENTRY;
                end
            end
            ENTRY: begin
                // A button edge outranks a same-cycle key and a timeout expiry.
                if (alarm_rise || time_rise) begin
                    if ((count == 3'd4) && bcd_time_ok(ms_hr, ls_hr, ms_min)) begin
                        load_alarm_d = alarm_rise;
                        load_time_d  = ~alarm_rise;
                    end else begin
                        err_d   = 1'b1;
                        buf_clr = 1'b1;
                    end
                    timeout_d = 4'd0;
                    state_d   = IDLE;
                end else if (digit_ok) begin
                    buf_shift = 1'b1;
                    timeout_d = 4'd0;
                end else if (one_second) begin
                    timeout_d = (timeout_q == 4'hF) ? timeout_q : timeout_q + 4'd1;
                    if (timeout_d >= TIMEOUT_LIM) begin
                        buf_clr   = 1'b1;
                        timeout_d = 4'd0;
                        state_d   = IDLE;
                    end
                end
            end
            SHOW_ALARM: begin
                if (!alarm_button)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        show_nt_d = (state_d == ENTRY);
        show_al_d = (state_d == SHOW_ALARM);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            alarm_prev_q <= 1'b0;
            time_prev_q  <= 1'b0;
            timeout_q    <= 4'd0;
            load_alarm_q <= 1'b0;
            load_time_q  <= 1'b0;
            err_q        <= 1'b0;
            show_nt_q    <= 1'b0;
            show_al_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            alarm_prev_q <= alarm_prev_d;
            time_prev_q  <= time_prev_d;
            timeout_q    <= timeout_d;
            load_alarm_q <= load_alarm_d;
            load_time_q  <= load_time_d;
            err_q        <= err_d;
            show_nt_q    <= show_nt_d;
            show_al_q    <= show_al_d;
        end
    end

    assign new_alarm_ms_hr  = ms_hr;
    assign new_alarm_ls_hr  = ls_hr;
    assign new_alarm_ms_min = ms_min;
    assign new_alarm_ls_min = ls_min;
    assign load_new_alarm   = load_alarm_q;
    assign load_new_time    = load_time_q;
    assign show_new_time    = show_nt_q;
    assign show_alarm       = show_al_q;
    assign entry_error      = err_q;

endmodule

// File: doc/alarm_key_entry.md
Name: alarm_key_entry

Overview:
- Keypad front-end for the alarm clock; sits directly upstream of the alarm register and the time counter.
- Collects up to four BCD digits (HH:MM) into a shift buffer and drives that buffer onto the register's new-alarm data inputs.
- On alarm_button it issues a one-cycle load_new_alarm strobe; on time_button it issues a one-cycle load_new_time strobe.
- Provides display-select flags and an inactivity timeout.

Parameters:
TIMEOUT_S, 10, number of one_second strobes without a key before an entry is abandoned (1..15)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
one_second  input  1  single-cycle strobe, once per second
key  input  4  keypad code; 0-9 are digits, 10-15 are non-digit and ignored
key_valid  input  1  single-cycle strobe qualifying key
alarm_button  input  1  level, synchronous to clock
time_button  input  1  level, synchronous to clock
new_alarm_ms_hr  output  4  buffer digit 3 (tens of hours)
new_alarm_ls_hr  output  4  buffer digit 2
new_alarm_ms_min  output  4  buffer digit 1
new_alarm_ls_min  output  4  buffer digit 0 (last key entered)
load_new_alarm  output  1  one-cycle strobe to alarm register
load_new_time  output  1  one-cycle strobe to time counter
show_new_time  output  1  display shows key buffer
show_alarm  output  1  display shows stored alarm time
entry_error  output  1  one-cycle strobe: load rejected

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; all four buffer digits 0; digit count 0; timeout count 0; all strobes and flags 0.
- All outputs are registered. Strobes appear the cycle after the triggering input edge and last exactly 1 cycle.
- Accepted digit: key_valid=1 and key<=9. Shift operation: ms_hr<=ls_hr, ls_hr<=ms_min, ms_min<=ls_min, ls_min<=key. Digit count increments and saturates at 4.
- States:
  - IDLE: show_new_time=0, show_alarm=0.
    - Accepted digit: clear the buffer, then place key in ls_min (one cycle, net result 0,0,0,key); count=1; timeout=0; go to ENTRY.
    - alarm_button=1: go to SHOW_ALARM.
    - time_button=1: ignored.
    - Non-digit key: ignored.
  - ENTRY: show_new_time=1.
    - Accepted digit: shift; timeout cleared.
    - one_second with no key that cycle: timeout increments. When it reaches TIMEOUT_S, clear buffer and count and go to IDLE. No strobe is issued.
    - alarm_button=1 (priority over time_button): evaluate the load, then go to IDLE.
    - time_button=1: same evaluation, then go to IDLE.
  - SHOW_ALARM: show_alarm=1 while alarm_button=1. Release returns to IDLE. Keys are ignored in this state.
- Load evaluation (in ENTRY only):
  - Valid when count==4 and ms_hr<=2 and ms_min<=5, and ls_hr<=3 when ms_hr==2.
  - Valid: pulse load_new_alarm or load_new_time. The buffer is held unchanged in the pulse cycle and after.
  - Invalid: pulse entry_error, clear the buffer, no load strobe.
- Simultaneous events in ENTRY:
  - Button and key_valid in the same cycle: button wins, key discarded.
  - Button and timeout expiry in the same cycle: button wins.
  - alarm_button and time_button together: alarm only.
- Buttons are level inputs. Transitions fire on the rising edge only (registered previous value). A held button never re-triggers.
- Reset asserted mid-entry: immediate return to the reset state; any pending strobe is lost.
- Timeout counter width is 4 bits. It saturates and never wraps.

Decomposition:
- Shared package: state encoding (IDLE, ENTRY, SHOW_ALARM), KEY_NONE=4'd10, DIGIT_MAX=4'd9, and the BCD hour/minute limit constants (2, 3, 5). The alarm register and time counter reuse the limit constants.
- One sub-module: alarm_key_shift. It holds the 4-digit shift buffer, with clear/shift/hold controls and digit-count output. The FSM, edge detect, timeout and validation stay in the top module.

Test Plan:
- Reset at 0, then keys 1,2,3,4 with one-cycle key_valid each -> buffer 1,2,3,4; show_new_time=1; count=4.
- Keys 2,3,5,9 then alarm_button rise -> load_new_alarm=1 for exactly 1 cycle with outputs 2,3,5,9; then IDLE with show_new_time=0.
- Keys 2,4,0,0 then time_button -> entry_error=1 for 1 cycle, no load strobe, buffer 0,0,0,0.
- Keys 1,2, then TIMEOUT_S=10 one_second strobes -> return to IDLE on the 10th; buffer 0; no strobe. Also apply a key after 9 strobes -> timeout restarts.
- Keys 0,7,3,0, then alarm_button and time_button raised in the same cycle -> only load_new_alarm pulses. Held buttons produce no second pulse.
- Mid-entry (two digits), reset=0 for half a cycle asynchronously -> all outputs 0 immediately. Key 11 in IDLE -> stays IDLE.
